keyboard_decoder: RTL and testbench

Parametrised PS/2 set-2 scan-code decoder that turns a stream of received bytes into per-key held levels plus one-cycle press/release pulses for a configurable table of keys. It sits between the PS/2 byte receiver and the game-control logic, and replaces the old purely combinational keycode compare. Unlike that compare, it tracks make/break state across bytes, so several keys can be held at once.

---
 rtl/keyboard_pkg.sv | 11 +
 rtl/keyboard_decoder_match.sv | 17 +
 rtl/keyboard_decoder.sv | 116 +++++++++++
 tb/tb_keyboard_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// keyboard_pkg: PS/2 set-2 byte constants, default key codes and decoder FSM states.
package keyboard_pkg;
    localparam logic [7:0] KEYCODE_RELEASE  = 8'hF0;
    localparam logic [7:0] KEYCODE_EXTENDED = 8'hE0;
    localparam logic [7:0] KEYCODE_OVERRUN0 = 8'h00;
    localparam logic [7:0] KEYCODE_OVERRUN1 = 8'hFF;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_RIGHT = 9'h023;
    localparam logic [8:0] KEY_LEFT  = 9'h01C;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_t;
endpackage

// File: rtl/keyboard_decoder_match.sv
// keycode_match: compares a 9-bit code against every key table entry; bit 8 only counts with KEYBOARD_EXT_EN.
module keycode_match #(
    parameter int NUM_KEYS = 3
) (
    input  logic [8:0]            code_i,
    input  logic [9*NUM_KEYS-1:0] table_i,
    output logic [NUM_KEYS-1:0]   match_o
);
`ifdef KEYBOARD_EXT_EN
    localparam logic [8:0] MASK = 9'h1FF;
`else
    localparam logic [8:0] MASK = 9'h0FF;
`endif
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        assign match_o[i] = ((table_i[9*i +: 9] ^ code_i) & MASK) == 9'h000;
    end
endmodule

// File: rtl/keyboard_decoder.sv
// keyboard_decoder: PS/2 set-2 make/break tracker giving held levels and press/release pulses.
// Extended (E0) codes are decoded only when KEYBOARD_EXT_EN is defined.
module keyboard_decoder
    import keyboard_pkg::*;
#(
    parameter int                     NUM_KEYS       = 3,
    parameter logic [9*NUM_KEYS-1:0]  KEY_CODES      = {KEY_LEFT, KEY_RIGHT, KEY_SPACE},
    parameter int                     PREFIX_TIMEOUT = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                prefix_pending
);
    localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
    kbd_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] held_q, held_d, press_q, press_d, release_q, release_d;
    logic [NUM_KEYS-1:0] match;
    logic [8:0]          code;
    logic                skip, timeout, mk, brk, is_f0, is_e0, is_ovr;

    assign code    = {state_q == EXT || state_q == EXT_BRK, byte_data};
    assign is_f0   = byte_data == KEYCODE_RELEASE;
    assign is_e0   = byte_data == KEYCODE_EXTENDED;
    assign is_ovr  = byte_data == KEYCODE_OVERRUN0 || byte_data == KEYCODE_OVERRUN1;
    assign timeout = state_q != IDLE && cnt_q >= CW'(PREFIX_TIMEOUT - 1);
`ifdef KEYBOARD_EXT_EN
    assign skip = 1'b0;
`else
    assign skip = is_e0;
`endif

    keycode_match #(.NUM_KEYS(NUM_KEYS)) u_match (
        .code_i (code),
        .table_i(KEY_CODES),
        .match_o(match)
    );

    // a byte arriving in the expiry cycle takes precedence over the timeout
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        press_d   = '0;
        release_d = '0;
        mk        = 1'b0;
        brk       = 1'b0;
        if (byte_valid) begin
            if (!skip) begin
                case (state_q)
                    IDLE: begin
                        if (is_f0) state_d = BRK;
                        else if (is_e0) state_d = EXT;
                        else if (is_ovr) begin
                            held_d    = '0;
                            release_d = held_q;
                        end else mk = 1'b1;
                    end
                    BRK: begin
                        if (!is_f0) begin
                            brk     = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    EXT: begin
                        if (is_f0) state_d = EXT_BRK;
                        else if (!is_e0) begin
                            mk      = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        brk     = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (timeout) state_d = IDLE;
        if (mk) begin
            held_d  = held_q | match;
            press_d = match & ~held_q;
        end
        if (brk) begin
            held_d    = held_q & ~match;
            release_d = match & held_q;
        end
    end

    assign cnt_d = byte_valid ? '0 :
                   (state_q != IDLE && cnt_q != {CW{1'b1}}) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_held       = held_q;
    assign key_press      = press_q;
    assign key_release    = release_q;
    assign prefix_pending = state_q != IDLE;
endmodule

// File: tb/tb_keyboard_decoder.sv
// tb_keyboard_decoder: directed byte sequences with hand-computed key levels and pulses.
module tb_keyboard_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [2:0] key_held, key_press, key_release;
    logic       prefix_pending;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    keyboard_decoder #(
        .NUM_KEYS      (3),
        .KEY_CODES     ({9'h174, 9'h023, 9'h029}),
        .PREFIX_TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .key_held      (key_held),
        .key_press     (key_press),
        .key_release   (key_release),
        .prefix_pending(prefix_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        idle(2);
        chk("rst_held", key_held, 3'b000);
        chk("rst_press", key_press, 3'b000);
        chk("rst_release", key_release, 3'b000);
        chk("rst_pending", prefix_pending, 1'b0);
        rst = 1'b0;
        idle(1);

        send(8'h29);
        chk("make29_held", key_held, 3'b001);
        chk("make29_press", key_press, 3'b001);
        send(8'h29);
        chk("repeat29_held", key_held, 3'b001);
        chk("repeat29_press", key_press, 3'b000);
        send(8'h23);
        chk("make23_held", key_held, 3'b011);
        chk("make23_press", key_press, 3'b010);
        send(8'hF0);
        chk("f0_pending", prefix_pending, 1'b1);
        chk("f0_held", key_held, 3'b011);
        send(8'h29);
        chk("brk29_held", key_held, 3'b010);
        chk("brk29_release", key_release, 3'b001);
        chk("brk29_pending", prefix_pending, 1'b0);
        idle(1);
        chk("brk29_pulse_end", key_release, 3'b000);

        send(8'hE0);
`ifdef KEYBOARD_EXT_EN
        chk("e0_pending", prefix_pending, 1'b1);
`else
        chk("e0_pending", prefix_pending, 1'b0);
`endif
        send(8'h74);
        chk("ext74_held", key_held, 3'b110);
        chk("ext74_press", key_press, 3'b100);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        chk("extbrk74_held", key_held, 3'b010);
        chk("extbrk74_release", key_release, 3'b100);
        send(8'h74);
`ifdef KEYBOARD_EXT_EN
        chk("plain74_held", key_held, 3'b010);
`else
        chk("plain74_held", key_held, 3'b110);
        send(8'hF0);
        send(8'h74);
`endif
        chk("after74_held", key_held, 3'b010);

        send(8'hF0);
        idle(15);
        chk("to_pending_hi", prefix_pending, 1'b1);
        idle(1);
        chk("to_pending_lo", prefix_pending, 1'b0);
        send(8'h29);
        chk("to_held", key_held, 3'b011);
        chk("to_press", key_press, 3'b001);
        chk("to_release", key_release, 3'b000);

        send(8'hF0);
        idle(15);
        send(8'h29);
        chk("bytewins_held", key_held, 3'b010);
        chk("bytewins_release", key_release, 3'b001);

        send(8'h29);
        send(8'hE0);
        send(8'h74);
        send(8'hF0);
        send(8'h23);
        chk("pre_ovr_held", key_held, 3'b101);
        send(8'hFF);
        chk("ovr_held", key_held, 3'b000);
        chk("ovr_release", key_release, 3'b101);
        chk("ovr_press", key_press, 3'b000);
        idle(1);
        chk("ovr_pulse_end", key_release, 3'b000);

        send(8'h1C);
        chk("unmatched_held", key_held, 3'b000);
        send(8'h29);
        send(8'hF0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_held", key_held, 3'b000);
        chk("midrst_release", key_release, 3'b000);
        chk("midrst_pending", prefix_pending, 1'b0);
        send(8'h23);
        chk("postrst_held", key_held, 3'b010);
        chk("postrst_press", key_press, 3'b010);
        chk("postrst_release", key_release, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
